// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Conditions the four raw direction pushbuttons into clean debounced levels
// plus single-cycle press/release pulses for the position controller.
//
// Each bit passes through a 2-flop synchronizer (s1 -> s2) and a debounce
// counter. The stable state (stb) flips only after s2 has disagreed with it
// for DEBOUNCE_CYCLES consecutive cycles. Bits are fully independent.
//
// Optional feature: define BTN_AUTOREPEAT_EN to compile in a per-bit
// auto-repeat FSM that re-fires btn_press while a button stays held
// (first repeat REPEAT_DELAY cycles after the press, then every
// REPEAT_PERIOD cycles). Without the macro, btn_press fires once per press.
//
// Ports:
//   clk          - single clock, all state on its rising edge
//   rst          - asynchronous, active-high reset
//   btn_raw[3:0] - raw pins: bit0 right, bit1 left, bit2 down, bit3 up
//   right/left/down/up - debounced levels
//   btn_press    - one-cycle pulse per bit on debounced press (and repeats)
//   btn_release  - one-cycle pulse per bit on debounced release
//   any_held     - OR of the four debounced levels
// -----------------------------------------------------------------------------
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_PERIOD   = 10000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] btn_raw,
   output logic       right,
   output logic       left,
   output logic       down,
   output logic       up,
   output logic [3:0] btn_press,
   output logic [3:0] btn_release,
   output logic       any_held
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Elaboration-time guard on the legal parameter ranges.
   if (DEBOUNCE_CYCLES < 2 || REPEAT_PERIOD < 2 || REPEAT_DELAY < 1) begin : g_bad_params
      $error("button_conditioner: illegal DEBOUNCE/REPEAT parameters");
   end

   logic [3:0]       s1;
   logic [3:0]       s2;
   logic [3:0]       stb;
   logic [CNT_W-1:0] cnt [4];

   logic [3:0] flip;       // stb flips on the coming edge
   logic [3:0] press_ev;   // debounced 0->1 on the coming edge
   logic [3:0] rel_ev;     // debounced 1->0 on the coming edge

   // NOTE: every always_comb output is assigned on every path, so no latches.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         flip[i] = (s2[i] != stb[i]) && (cnt[i] == CNT_LAST);
      end
      press_ev = flip & ~stb;
      rel_ev   = flip & stb;
   end

   // NOTE: sequential state uses non-blocking (<=) so all flops update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1          <= '0;
         s2          <= '0;
         stb         <= '0;
         btn_release <= '0;
         any_held    <= 1'b0;
         // NOTE: the counters are four small flop registers, not a RAM, so they
         // are reset like any other state.
         for (int i = 0; i < 4; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         s1 <= btn_raw;
         s2 <= s1;
         for (int i = 0; i < 4; i++) begin
            // Any agreeing sample restarts the count, rejecting short glitches.
            if (s2[i] == stb[i] || flip[i]) begin
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
         stb         <= stb ^ flip;
         btn_release <= rel_ev;
         any_held    <= |(stb ^ flip);
      end
   end

   assign right = stb[0];
   assign left  = stb[1];
   assign down  = stb[2];
   assign up    = stb[3];

`ifdef BTN_AUTOREPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RCNT_W  = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;
   localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
   localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {
      IDLE,
      DELAY,
      REPEAT
   } rpt_state_t;

   rpt_state_t        state [4];
   logic [RCNT_W-1:0] rcnt  [4];
   logic [3:0]        tick;   // repeat counter expires on the coming edge

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         tick[i] = ((state[i] == DELAY)  && (rcnt[i] == DELAY_LAST)) ||
                   ((state[i] == REPEAT) && (rcnt[i] == PERIOD_LAST));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_press <= '0;
         for (int i = 0; i < 4; i++) begin
            state[i] <= IDLE;
            rcnt[i]  <= '0;
         end
      end else begin
         // A release wins over a repeat tick landing on the same edge.
         btn_press <= press_ev | (tick & ~rel_ev);
         for (int i = 0; i < 4; i++) begin
            if (rel_ev[i]) begin
               state[i] <= IDLE;
               rcnt[i]  <= '0;
            end else begin
               case (state[i])
                  IDLE: begin
                     if (press_ev[i]) begin
                        state[i] <= DELAY;
                        rcnt[i]  <= '0;
                     end
                  end
                  DELAY: begin
                     if (tick[i]) begin
                        state[i] <= REPEAT;
                        rcnt[i]  <= '0;
                     end else begin
                        rcnt[i] <= rcnt[i] + 1'b1;
                     end
                  end
                  REPEAT: begin
                     if (tick[i]) begin
                        rcnt[i] <= '0;
                     end else begin
                        rcnt[i] <= rcnt[i] + 1'b1;
                     end
                  end
                  default: begin
                     state[i] <= IDLE;
                     rcnt[i]  <= '0;
                  end
               endcase
            end
         end
      end
   end
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_press <= '0;
      end else begin
         btn_press <= press_ev;
      end
   end
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=3. Inputs change 1 time unit after a rising
// edge; outputs are sampled at the same point. "Edge 0" is the first rising
// edge that samples a new btn_raw value, so a debounced change is visible
// after edge 5 (6 steps later). Expectations for the auto-repeat case follow
// BTN_AUTOREPEAT_EN.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] btn_raw;
   logic       right, left, down, up;
   logic [3:0] btn_press;
   logic [3:0] btn_release;
   logic       any_held;

   int n_tests = 0;
   int n_fail  = 0;

   button_conditioner #(
      .DEBOUNCE_CYCLES (4),
      .REPEAT_DELAY    (10),
      .REPEAT_PERIOD   (3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_raw     (btn_raw),
      .right       (right),
      .left        (left),
      .down        (down),
      .up          (up),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .any_held    (any_held)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [3:0] levels();
      return {up, down, left, right};
   endfunction

   logic [3:0]  bounce_seq [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
   logic [2:0]  bounce_acc;
   logic [31:0] rpt_mask;
   logic [31:0] rpt_exp;
   logic [3:0]  other_press;
   logic [3:0]  rel_at_25;
   logic        left_at_24;
   logic        left_at_25;

   initial begin
      rst     = 1'b1;
      btn_raw = 4'b0000;
      step(2);
      check("reset_levels",  {28'd0, levels()},     32'h0);
      check("reset_press",   {28'd0, btn_press},    32'h0);
      check("reset_release", {28'd0, btn_release},  32'h0);
      check("reset_any",     {31'd0, any_held},     32'h0);
      rst = 1'b0;
      step(2);

      // ---- clean press / release on bit 0 -----------------------------------
      btn_raw = 4'b0001;
      step(5);
      check("clean_levels_early", {28'd0, levels()},  32'h0);
      check("clean_press_early",  {28'd0, btn_press}, 32'h0);
      step(1);
      check("clean_levels",  {28'd0, levels()},    32'h1);
      check("clean_press",   {28'd0, btn_press},   32'h1);
      check("clean_any",     {31'd0, any_held},    32'h1);
      check("clean_no_rel",  {28'd0, btn_release}, 32'h0);
      step(1);
      check("clean_press_width", {28'd0, btn_press}, 32'h0);
      check("clean_still_held",  {28'd0, levels()},  32'h1);
      btn_raw = 4'b0000;
      step(5);
      check("clean_rel_early",  {28'd0, btn_release}, 32'h0);
      check("clean_held_early", {28'd0, levels()},    32'h1);
      step(1);
      check("clean_release",     {28'd0, btn_release}, 32'h1);
      check("clean_levels_drop", {28'd0, levels()},    32'h0);
      check("clean_any_drop",    {31'd0, any_held},    32'h0);
      step(1);
      check("clean_release_width", {28'd0, btn_release}, 32'h0);

      // ---- bounce rejection on bit 3 ----------------------------------------
      bounce_acc = '0;
      for (int i = 0; i < 7; i++) begin
         btn_raw = {bounce_seq[i][0], 3'b000};
         step(1);
         bounce_acc |= {up, btn_press[3], btn_release[3]};
      end
      btn_raw = 4'b0000;
      for (int i = 0; i < 8; i++) begin
         step(1);
         bounce_acc |= {up, btn_press[3], btn_release[3]};
      end
      check("bounce_up",      {31'd0, bounce_acc[2]}, 32'h0);
      check("bounce_press",   {31'd0, bounce_acc[1]}, 32'h0);
      check("bounce_release", {31'd0, bounce_acc[0]}, 32'h0);

      // ---- long hold then release on bit 2 ----------------------------------
      btn_raw = 4'b0100;
      step(20);
      check("hold_down", {28'd0, levels()}, 32'h4);
      btn_raw = 4'b0000;
      step(5);
      check("hold_rel_early",  {28'd0, btn_release}, 32'h0);
      check("hold_down_early", {28'd0, levels()},    32'h4);
      step(1);
      check("hold_release",       {28'd0, btn_release}, 32'h4);
      check("hold_levels_drop",   {28'd0, levels()},    32'h0);
      check("hold_press_on_rel",  {28'd0, btn_press},   32'h0);
      step(1);
      check("hold_release_width", {28'd0, btn_release}, 32'h0);

      // ---- auto-repeat on bit 1, release landing on a repeat tick ----------
      btn_raw = 4'b0010;
      step(6);
      check("rpt_first_press", {28'd0, btn_press}, 32'h2);
      rpt_mask    = '0;
      other_press = '0;
      rel_at_25   = '0;
      left_at_24  = 1'b0;
      left_at_25  = 1'b1;
      for (int o = 1; o <= 28; o++) begin
         // Raw drop sampled at press+20 debounces out at press+25, a tick edge.
         if (o == 20) btn_raw = 4'b0000;
         step(1);
         rpt_mask[o]  = btn_press[1];
         other_press |= btn_press & 4'b1101;
         if (o == 24) left_at_24 = left;
         if (o == 25) begin
            left_at_25 = left;
            rel_at_25  = btn_release;
         end
      end
`ifdef BTN_AUTOREPEAT_EN
      rpt_exp = (32'd1 << 10) | (32'd1 << 13) | (32'd1 << 16) | (32'd1 << 19) | (32'd1 << 22);
`else
      rpt_exp = 32'h0;
`endif
      check("rpt_pulse_mask",   rpt_mask,                rpt_exp);
      check("rpt_other_bits",   {28'd0, other_press},    32'h0);
      check("rpt_held_at_24",   {31'd0, left_at_24},     32'h1);
      check("rpt_drop_at_25",   {31'd0, left_at_25},     32'h0);
      check("rpt_release_25",   {28'd0, rel_at_25},      32'h2);

      // ---- simultaneous up + down -------------------------------------------
      btn_raw = 4'b1100;
      step(5);
      check("simul_press_early", {28'd0, btn_press}, 32'h0);
      step(1);
      check("simul_levels", {28'd0, levels()},  32'hC);
      check("simul_press",  {28'd0, btn_press}, 32'hC);
      check("simul_any",    {31'd0, any_held},  32'h1);
      btn_raw = 4'b0000;
      step(6);
      check("simul_release", {28'd0, btn_release}, 32'hC);
      check("simul_drop",    {28'd0, levels()},    32'h0);

      // ---- reset while left is held mid-repeat ------------------------------
      btn_raw = 4'b0010;
      step(6);
      check("rst_first_press", {28'd0, btn_press}, 32'h2);
      step(12);
      check("rst_left_held", {28'd0, levels()}, 32'h2);
      #2;
      rst = 1'b1;
      #1;
      check("rst_async_levels",  {28'd0, levels()},    32'h0);
      check("rst_async_press",   {28'd0, btn_press},   32'h0);
      check("rst_async_release", {28'd0, btn_release}, 32'h0);
      check("rst_async_any",     {31'd0, any_held},    32'h0);
      step(2);
      check("rst_held_outputs", {19'd0, levels(), btn_press, btn_release, any_held}, 32'h0);
      rst = 1'b0;
      step(5);
      check("rst_repress_early", {28'd0, btn_press}, 32'h0);
      check("rst_left_early",    {28'd0, levels()},  32'h0);
      step(1);
      check("rst_repress",      {28'd0, btn_press}, 32'h2);
      check("rst_repress_left", {28'd0, levels()},  32'h2);
      step(1);
      check("rst_repress_width", {28'd0, btn_press}, 32'h0);

      btn_raw = 4'b0000;
      step(8);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
